network_target_interface: RTL and testbench
===========================================

# network_target_interface

Target-side network interface: the responder end of the NoC memory-access protocol used by the node initiators. It accepts request packets from its router's ejection port, decodes the header, performs the access on a local memory port, and returns read data to the requester as a single response flit. Writes are posted: no response is generated.

## Interface
- DATA_WIDTH, 32, flit and memory data width; must be ≥ 32.
- ADDR_WIDTH, 32, local memory address width; must be ≥ 12.
- NODE_ID, 0, this node's 8-bit ID; headers addressed elsewhere are dropped.

- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  DATA_WIDTH  flit from router ejection port.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  flit accepted when rx_valid && rx_ready.
- tx_data  out  DATA_WIDTH  response flit toward router injection port.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  router accepts when tx_valid && tx_ready.
- mem_req  out  1  local access request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_WIDTH  zero-extended 12-bit packet address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read data.
- last_src  out  8  source ID of last accepted, correctly addressed header.
- last_type  out  3  msg_type of that header.
- drop_count  out  8  misaddressed headers, saturating.
- busy  out  1  state ≠ IDLE.

## Operation
- Header flit: [DW-1:DW-8] dest, [DW-9:DW-11] msg_type, [DW-12:DW-19] src, [DW-20] write, [11:0] address. Bits between are ignored.
- Write request: header followed by exactly one data flit. Read request: header only. Response: one flit, raw mem_rdata.
- States: IDLE, WDATA, DROP, MEM_WR, MEM_RD, RD_WAIT, SEND.
- IDLE: rx_ready=1. On header accept:
  - If dest ≠ NODE_ID: drop_count++ (saturate at 255). Go to DROP if write=1, else stay in IDLE.
  - Otherwise latch address, src and type. Go to WDATA if write=1, else MEM_RD.
- WDATA: rx_ready=1. On accept, latch mem_wdata and go to MEM_WR.
- DROP: rx_ready=1. Consume one flit with no other effect, then go to IDLE.
- MEM_WR: mem_req=1, mem_we=1. On mem_gnt, go to IDLE.
- MEM_RD: mem_req=1, mem_we=0. On mem_gnt:
  - if mem_rvalid is also high that cycle, capture mem_rdata and go to SEND;
  - else go to RD_WAIT.
- RD_WAIT: on mem_rvalid, capture mem_rdata and go to SEND. mem_rvalid outside MEM_RD/RD_WAIT is ignored.
- SEND: tx_valid=1, tx_data held stable. On tx_ready, go to IDLE.
- rx_ready=0 in MEM_WR, MEM_RD, RD_WAIT, SEND and while rst=1. One transaction is in flight at a time.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_gnt cycle.

## Timing
- Reset (synchronous): state=IDLE. All outputs 0, including tx_data, mem_addr, mem_wdata, last_src, last_type and drop_count. rx_ready is 1 from the first cycle after rst deasserts.
- Reset mid-operation: any state returns to IDLE on the next edge. In-flight mem_req, tx_valid and partial packets are abandoned with no response.
- Read, gnt=rvalid same cycle, tx_ready=1: header accepted at edge N; mem_req high in cycle N+1; tx_valid high in cycle N+2; rx_ready high again in cycle N+3.
- Write, gnt immediate: data flit accepted at edge N+1; mem_req high in cycle N+2; rx_ready high in cycle N+3.
- mem_gnt latency: unbounded. tx_ready stall: unbounded, with no flit loss.
- last_src and last_type update on the edge that accepts a correctly addressed header.
- busy is combinational from state.

## Test plan
- Read: NODE_ID=5; header dest=5, src=2, type=3, write=0, addr=0x0A4; memory returns 0xDEADBEEF with gnt=rvalid -> mem_addr=0x0A4, mem_we=0; tx_data=0xDEADBEEF; tx_valid in cycle N+2; last_src=2, last_type=3.
- Write: header dest=5, write=1, addr=0xFFF, then data 0x12345678; mem_gnt delayed 3 cycles -> mem_req held 4 cycles with mem_we=1, mem_addr=0xFFF, mem_wdata=0x12345678 stable; no tx_valid.
- Misaddressed write: header dest=7, write=1, then data flit -> both flits consumed; no mem_req; drop_count=1; last_src unchanged.
- Backpressure: read with tx_ready=0 for 5 cycles -> tx_valid and tx_data stable; rx_ready=0 throughout; completes in the cycle tx_ready=1.
- Split read: gnt in cycle K, rvalid in cycle K+4 -> tx_valid first in cycle K+5; a stray rvalid sent while in IDLE is ignored.
- Reset/saturation:
  - rst pulsed in RD_WAIT -> all outputs 0, rx_ready=1 after release, and no tx flit is sent.
  - 300 misaddressed reads -> drop_count=255.

Source files
------------

// File: rtl/network_target_interface.sv
// rtl/network_target_interface.sv - NoC target interface: decodes request packets, drives local memory, returns read data.
module network_target_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [7:0] NODE_ID = 8'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            last_src,
  output logic [2:0]            last_type,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WDATA   = 3'd1,
    DROP    = 3'd2,
    MEM_WR  = 3'd3,
    MEM_RD  = 3'd4,
    RD_WAIT = 3'd5,
    SEND    = 3'd6
  } state_t;

  state_t state, state_next;

  logic [7:0]  hdr_dest;
  logic [2:0]  hdr_type;
  logic [7:0]  hdr_src;
  logic        hdr_write;
  logic [11:0] hdr_addr;
  logic        hdr_for_us;
  logic        rx_fire;

  assign hdr_dest   = rx_data[DATA_WIDTH-1 -: 8];
  assign hdr_type   = rx_data[DATA_WIDTH-9 -: 3];
  assign hdr_src    = rx_data[DATA_WIDTH-12 -: 8];
  assign hdr_write  = rx_data[DATA_WIDTH-20];
  assign hdr_addr   = rx_data[11:0];
  assign hdr_for_us = (hdr_dest == NODE_ID);
  assign rx_fire    = rx_valid && rx_ready;

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (!hdr_for_us) state_next = hdr_write ? DROP : IDLE;
          else             state_next = hdr_write ? WDATA : MEM_RD;
        end
      end
      WDATA: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = MEM_WR;
      end
      DROP: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = IDLE;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_next = IDLE;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = mem_rvalid ? SEND : RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) state_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Nothing is accepted while reset is held, even though state updates only at the edge.
    if (rst) rx_ready = 1'b0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tx_data    <= '0;
      last_src   <= '0;
      last_type  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (!hdr_for_us) begin
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
              mem_addr  <= {{(ADDR_WIDTH-12){1'b0}}, hdr_addr};
              last_src  <= hdr_src;
              last_type <= hdr_type;
            end
          end
        end
        WDATA: begin
          if (rx_fire) mem_wdata <= rx_data;
        end
        MEM_RD: begin
          if (mem_gnt && mem_rvalid) tx_data <= mem_rdata;
        end
        RD_WAIT: begin
          if (mem_rvalid) tx_data <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_network_target_interface.sv
// tb/tb_network_target_interface.sv - directed self-checking bench for network_target_interface.
module tb_network_target_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [7:0]  last_src;
  logic [2:0]  last_type;
  logic [7:0]  drop_count;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  network_target_interface #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NODE_ID(8'd5)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .last_src(last_src), .last_type(last_type), .drop_count(drop_count), .busy(busy)
  );

  function automatic logic [31:0] hdr(input logic [7:0] dest, input logic [2:0] typ,
                                      input logic [7:0] src, input logic wr, input logic [11:0] addr);
    return {dest, typ, src, wr, addr};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    total++; if (tx_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctrl got tx_valid=%b mem_req=%b busy=%b exp=0", tx_valid, mem_req, busy); end
    total++; if (tx_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_data got tx=%h addr=%h wdata=%h exp=0", tx_data, mem_addr, mem_wdata); end
    total++; if (last_src !== 8'h0 || last_type !== 3'h0 || drop_count !== 8'h0) begin bad++; $display("FAIL reset_status got src=%h type=%h drops=%h exp=0", last_src, last_type, drop_count); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_release_rx_ready got=%b exp=1", rx_ready); end
  endtask

  task automatic test_read();
    rx_valid = 1'b1; rx_data = hdr(8'd5, 3'd3, 8'd2, 1'b0, 12'h0A4); tx_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL read_req got req=%b we=%b exp=1/0", mem_req, mem_we); end
    total++; if (mem_addr !== 32'h0A4) begin bad++; $display("FAIL read_addr got=%h exp=000000a4", mem_addr); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL read_rx_ready_busy got=%b exp=0", rx_ready); end
    total++; if (last_src !== 8'd2 || last_type !== 3'd3) begin bad++; $display("FAIL read_last got src=%0d type=%0d exp=2/3", last_src, last_type); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++; if (tx_valid !== 1'b1 || tx_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_resp got valid=%b data=%h exp=1/deadbeef", tx_valid, tx_data); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL read_req_drop got=%b exp=0", mem_req); end
    @(negedge clk);
    total++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL read_done got rx_ready=%b tx_valid=%b busy=%b exp=1/0/0", rx_ready, tx_valid, busy); end
  endtask

  task automatic test_write();
    rx_valid = 1'b1; rx_data = hdr(8'd5, 3'd1, 8'd9, 1'b1, 12'hFFF);
    @(negedge clk);
    total++; if (rx_ready !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL write_wdata_state got rx_ready=%b mem_req=%b exp=1/0", rx_ready, mem_req); end
    rx_data = 32'h12345678;
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL write_req_%0d got req=%b we=%b exp=1/1", i, mem_req, mem_we); end
      total++; if (mem_addr !== 32'hFFF || mem_wdata !== 32'h12345678) begin bad++; $display("FAIL write_bus_%0d got addr=%h wdata=%h exp=00000fff/12345678", i, mem_addr, mem_wdata); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL write_no_tx_%0d got=%b exp=0", i, tx_valid); end
      if (i == 3) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0) begin bad++; $display("FAIL write_done got req=%b rx_ready=%b tx_valid=%b exp=0/1/0", mem_req, rx_ready, tx_valid); end
  endtask

  task automatic test_misaddressed();
    rx_valid = 1'b1; rx_data = hdr(8'd7, 3'd2, 8'h44, 1'b1, 12'h123);
    @(negedge clk);
    total++; if (busy !== 1'b1 || rx_ready !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL drop_state got busy=%b rx_ready=%b req=%b exp=1/1/0", busy, rx_ready, mem_req); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
    rx_data = 32'h05000000;
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || drop_count !== 8'd1) begin bad++; $display("FAIL drop_done got busy=%b req=%b drops=%0d exp=0/0/1", busy, mem_req, drop_count); end
    total++; if (last_src !== 8'd9 || last_type !== 3'd1) begin bad++; $display("FAIL drop_last got src=%0d type=%0d exp=9/1", last_src, last_type); end
  endtask

  task automatic test_backpressure();
    rx_valid = 1'b1; rx_data = hdr(8'd5, 3'd4, 8'd3, 1'b0, 12'h010); tx_ready = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 32'hCAFEF00D) begin bad++; $display("FAIL bp_hold_%0d got valid=%b data=%h exp=1/cafef00d", i, tx_valid, tx_data); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL bp_rx_ready_%0d got=%b exp=0", i, rx_ready); end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", tx_valid); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL bp_done got tx_valid=%b rx_ready=%b exp=0/1", tx_valid, rx_ready); end
  endtask

  task automatic test_split_read();
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL stray_rvalid got busy=%b tx_valid=%b exp=0/0", busy, tx_valid); end
    rx_valid = 1'b1; rx_data = hdr(8'd5, 3'd0, 8'd6, 1'b0, 12'h03C);
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h03C) begin bad++; $display("FAIL split_req got req=%b addr=%h exp=1/0000003c", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++; if (tx_valid !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL split_wait_%0d got tx_valid=%b busy=%b req=%b exp=0/1/0", i, tx_valid, busy, mem_req); end
      if (i == 4) begin mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D; end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    total++; if (tx_valid !== 1'b1 || tx_data !== 32'h0BADF00D) begin bad++; $display("FAIL split_resp got valid=%b data=%h exp=1/0badf00d", tx_valid, tx_data); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL split_done got busy=%b tx_valid=%b exp=0/0", busy, tx_valid); end
  endtask

  task automatic test_reset_mid();
    rx_valid = 1'b1; rx_data = hdr(8'd5, 3'd6, 8'd8, 1'b0, 12'h0AB);
    @(negedge clk);
    rx_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    total++; if (busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_rdwait got busy=%b req=%b exp=1/0", busy, mem_req); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got busy=%b rx_ready=%b tx_valid=%b req=%b exp=0", busy, rx_ready, tx_valid, mem_req); end
    total++; if (mem_addr !== 32'h0 || tx_data !== 32'h0 || mem_wdata !== 32'h0 || last_src !== 8'h0 || last_type !== 3'h0 || drop_count !== 8'h0) begin bad++; $display("FAIL rst_mid_regs got addr=%h tx=%h wdata=%h src=%h type=%h drops=%h exp=0", mem_addr, tx_data, mem_wdata, last_src, last_type, drop_count); end
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFEEDFACE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_release got=%b exp=1", rx_ready); end
    for (int i = 0; i < 3; i++) begin
      total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_no_tx_%0d got tx_valid=%b busy=%b exp=0/0", i, tx_valid, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    rx_valid = 1'b1; rx_data = hdr(8'h22, 3'd0, 8'd1, 1'b0, 12'h000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 99) begin
        total++; if (drop_count !== 8'd100) begin bad++; $display("FAIL sat_mid got=%0d exp=100", drop_count); end
      end
    end
    rx_valid = 1'b0;
    @(negedge clk);
    total++; if (drop_count !== 8'd255 || busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL sat_final got drops=%0d busy=%b req=%b exp=255/0/0", drop_count, busy, mem_req); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_misaddressed();
    test_backpressure();
    test_split_read();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
